// File: rtl/map_mem_pkg.sv
// Shared types and defaults for the cartridge memory arbiter.
package map_mem_pkg;

  // Default memory word address width, matching the mapper bus.
  localparam int ADDR_BITS_DEF = 22;

  // Which requester owns the access currently on the memory port.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CHR,
    OWN_PRG,
    OWN_LD
  } owner_t;

  // Arbiter state: waiting for work, or holding a request until ack.
  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

endpackage

// File: rtl/map_req_detect.sv
// New-access detector with a one-deep pending slot for one NES-side requester.
// A request is new when the enable rises, or when the address differs from the
// most recent address this slot has latched (pending) or handed out (served).
module map_req_detect #(
  parameter int ADDR_BITS = 22,
  parameter int PAY_W     = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [PAY_W-1:0]     payload,
  input  logic                 grant,
  output logic                 pend,
  output logic [ADDR_BITS-1:0] pend_addr,
  output logic [PAY_W-1:0]     pend_payload
);

  logic                 active_prev_reg;
  logic                 pend_reg;
  logic [ADDR_BITS-1:0] pend_addr_reg;
  logic [ADDR_BITS-1:0] last_addr_reg;
  logic [PAY_W-1:0]     pend_payload_reg;
  logic [ADDR_BITS-1:0] ref_addr;
  logic                 hit;

  // Comparing against the pending address keeps a held, unchanged address from
  // re-triggering on the very edge its pending slot is granted.
  assign ref_addr = pend_reg ? pend_addr_reg : last_addr_reg;
  assign hit      = active && (!active_prev_reg || (addr != ref_addr));

  // Track enable history, latch new requests (newest wins), retire on grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_prev_reg  <= 1'b0;
      pend_reg         <= 1'b0;
      pend_addr_reg    <= '0;
      last_addr_reg    <= '0;
      pend_payload_reg <= '0;
    end else begin
      active_prev_reg <= active;
      if (grant) begin
        last_addr_reg <= pend_addr_reg;
        pend_reg      <= 1'b0;
      end
      if (hit) begin
        pend_reg         <= 1'b1;
        pend_addr_reg    <= addr;
        pend_payload_reg <= payload;
      end
    end
  end

  assign pend         = pend_reg;
  assign pend_addr    = pend_addr_reg;
  assign pend_payload = pend_payload_reg;

endmodule

// File: rtl/map_mem_arbiter.sv
// Shares one req/ack memory port between mapper PRG reads, mapper CHR
// reads/writes and the ROM loader. Fixed priority CHR > PRG > LD.
// Optional loader starvation guard: define MAP_ARB_STARVE_GUARD_EN.
module map_mem_arbiter
  import map_mem_pkg::*;
#(
  parameter int ADDR_BITS    = ADDR_BITS_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] prg_addr,
  input  logic                 prg_oe,
  output logic [7:0]           prg_data,
  input  logic [ADDR_BITS-1:0] chr_addr,
  input  logic                 chr_oe,
  input  logic                 chr_we,
  input  logic [7:0]           chr_wdata,
  output logic [7:0]           chr_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [7:0]           ld_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata
);

  // The guard counter is 4 bits wide, so the limit has to fit in it.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
  end

  arb_state_t           state_reg, state_next;
  owner_t               owner_reg;
  logic                 mem_req_reg, mem_we_reg;
  logic [ADDR_BITS-1:0] mem_addr_reg;
  logic [7:0]           mem_wdata_reg, prg_data_reg, chr_data_reg;
  logic                 ld_ready_reg, ld_pend_reg;
  logic                 grant_chr, grant_prg, grant_ld;
  logic                 chr_pend, prg_pend;
  logic [ADDR_BITS-1:0] chr_pend_addr, prg_pend_addr;
  logic [8:0]           chr_pend_pay, prg_pend_pay;
  logic                 ld_ok, ld_done, ack_done, starve_force;

  map_req_detect #(.ADDR_BITS(ADDR_BITS), .PAY_W(9)) u_chr_detect (
    .clk          (clk),
    .reset        (reset),
    .active       (chr_oe | chr_we),
    .addr         (chr_addr),
    .payload      ({chr_we, chr_wdata}),
    .grant        (grant_chr),
    .pend         (chr_pend),
    .pend_addr    (chr_pend_addr),
    .pend_payload (chr_pend_pay)
  );

  // PRG is read-only: its payload is a constant read with zero write data.
  map_req_detect #(.ADDR_BITS(ADDR_BITS), .PAY_W(9)) u_prg_detect (
    .clk          (clk),
    .reset        (reset),
    .active       (prg_oe),
    .addr         (prg_addr),
    .payload      (9'd0),
    .grant        (grant_prg),
    .pend         (prg_pend),
    .pend_addr    (prg_pend_addr),
    .pend_payload (prg_pend_pay)
  );

  // The loader qualifier lags ld_valid by one cycle, giving the loader the same
  // detect-then-grant latency as NES requests, and it is dropped in the ld_ready
  // cycle so a loader that has not yet released ld_valid is not served twice.
  assign ld_ok    = ld_valid && ld_pend_reg;
  assign ack_done = (state_reg == BUSY) && mem_ack;
  assign ld_done  = ack_done && (owner_reg == OWN_LD);

`ifdef MAP_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_THR = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_reg;

  // Count NES grants that bypass a waiting loader; cleared when LD is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= 4'd0;
    end else if (grant_ld) begin
      starve_cnt_reg <= 4'd0;
    end else if ((grant_chr || grant_prg) && ld_valid && (starve_cnt_reg != 4'hF)) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  assign starve_force = ld_ok && (starve_cnt_reg >= STARVE_THR);
`else
  assign starve_force = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Grant selection in IDLE; leave BUSY on ack.
  always_comb begin
    state_next = state_reg;
    grant_chr  = 1'b0;
    grant_prg  = 1'b0;
    grant_ld   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (starve_force)  grant_ld  = 1'b1;
        else if (chr_pend) grant_chr = 1'b1;
        else if (prg_pend) grant_prg = 1'b1;
        else if (ld_ok)    grant_ld  = 1'b1;
        if (grant_chr || grant_prg || grant_ld) state_next = BUSY;
      end
      BUSY: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory port drive on grant, completion handling and read data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg     <= OWN_NONE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 8'd0;
      prg_data_reg  <= 8'd0;
      chr_data_reg  <= 8'd0;
      ld_ready_reg  <= 1'b0;
      ld_pend_reg   <= 1'b0;
    end else begin
      ld_ready_reg <= 1'b0;
      ld_pend_reg  <= ld_valid && !ld_done;
      if (grant_chr) begin
        owner_reg     <= OWN_CHR;
        mem_req_reg   <= 1'b1;
        mem_addr_reg  <= chr_pend_addr;
        mem_we_reg    <= chr_pend_pay[8];
        mem_wdata_reg <= chr_pend_pay[7:0];
      end else if (grant_prg) begin
        owner_reg     <= OWN_PRG;
        mem_req_reg   <= 1'b1;
        mem_addr_reg  <= prg_pend_addr;
        mem_we_reg    <= prg_pend_pay[8];
        mem_wdata_reg <= prg_pend_pay[7:0];
      end else if (grant_ld) begin
        owner_reg     <= OWN_LD;
        mem_req_reg   <= 1'b1;
        mem_addr_reg  <= ld_addr;
        mem_we_reg    <= 1'b1;
        mem_wdata_reg <= ld_data;
      end
      if (ack_done) begin
        mem_req_reg <= 1'b0;
        case (owner_reg)
          OWN_CHR: if (!mem_we_reg) chr_data_reg <= mem_rdata;
          OWN_PRG: prg_data_reg <= mem_rdata;
          OWN_LD:  ld_ready_reg <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign prg_data  = prg_data_reg;
  assign chr_data  = chr_data_reg;
  assign ld_ready  = ld_ready_reg;

endmodule
